alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational Alu instance between two requesters using a valid/ready handshake. Arbitration is round-robin or fixed-priority. The block registers the selected operation onto the Alu inputs and captures Result plus the Zero/Carry/Negative flags one cycle later. It returns a tagged response and sits between the fetch/execute control path and the Alu datapath.

Parameters:
OPCODE_MAX, 4, highest legal Alu opcode; any opcode above this is rejected with an error response.
FIXED_PRIO, 0, 0 = round-robin; 1 = req0 always wins a conflict.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_opcode  in  8  requester 0 opcode
req0_a  in  8  requester 0 operand A
req0_b  in  8  requester 0 operand B
req1_valid / req1_ready / req1_opcode / req1_a / req1_b  same widths and meaning, requester 1
alu_opcode  out  8  registered opcode to Alu
alu_a  out  8  registered operand A to Alu
alu_b  out  8  registered operand B to Alu
alu_result  in  8  Alu Result
alu_zero  in  1  Alu Zero
alu_carry  in  1  Alu Carry
alu_negative  in  1  Alu Negative
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester index of response
rsp_result  out  8  captured result
rsp_flags  out  3  {negative, carry, zero}
rsp_err  out  1  illegal opcode
busy  out  1  state != IDLE
done_count  out  16  completed responses, wraps 0xFFFF->0x0000

Behaviour:
- Reset (async, rst_n=0): state=IDLE. These outputs are 0: alu_opcode, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, done_count. last_grant=1, so req0 wins the first conflict. Reset mid-operation discards any in-flight or pending response; no partial handshake survives.
- States:
  - IDLE: wait for a request.
  - EXEC: Alu inputs are stable for one full cycle.
  - RESP: hold the response until handshake.
- Grant (combinational, IDLE only):
  - Single valid requester: that requester is granted.
  - Both valid, FIXED_PRIO=1: req0 granted.
  - Both valid, FIXED_PRIO=0: the requester not equal to last_grant is granted.
  - reqN_ready = (state==IDLE) && granted N. Both ready signals are 0 outside IDLE.
  - last_grant updates only on an accept (valid&ready).
- Accept, legal opcode (opcode <= OPCODE_MAX):
  - Edge E0: alu_opcode/alu_a/alu_b load the granted fields; rsp_id := grant; state -> EXEC.
  - Edge E1: rsp_result := alu_result; rsp_flags := {alu_negative, alu_carry, alu_zero}; rsp_err := 0; rsp_valid := 1; state -> RESP.
  - Minimum accept-to-rsp_valid latency is 2 clocks.
- Accept, illegal opcode (> OPCODE_MAX):
  - Edge E0: state -> RESP directly with rsp_valid=1, rsp_err=1, rsp_result=0, rsp_flags=0.
  - alu_* registers are not updated.
  - Latency is 1 clock.
- RESP:
  - rsp_* held stable while rsp_ready=0.
  - Edge with rsp_valid&rsp_ready: rsp_valid := 0; done_count += 1 (modulo 2^16); state -> IDLE.
  - The next request can be accepted in the cycle after the handshake. There is no accept in the handshake cycle itself, so peak throughput is 1 operation per 3 clocks.
- alu_* registers hold their last value outside E0 loads; the Alu output is ignored except at E1.
- Requester dropping valid before ready: no effect, no state change.
- Requester changing fields while valid&!ready: the values present at the accept edge are used.
- Flags are taken verbatim from the Alu; no recomputation in this block.

Test Plan:
- Reset then req0 ADD (opcode 0x02) a=0xF0 b=0x20, rsp_ready=1 -> rsp_valid 2 clks after accept; rsp_id=0, result=0x10, flags=3'b010, err=0; done_count=1.
- req1 SUB (0x03) a=0x05 b=0x05 -> result=0x00, flags=3'b001; then SUB a=0x01 b=0x02 -> result=0xFF, flags=3'b100.
- Both valid continuously with AND ops, FIXED_PRIO=0 -> accepts alternate 0,1,0,1 starting with req0. With FIXED_PRIO=1 -> req0 only while it stays valid.
- rsp_ready held 0 for 3 clks in RESP -> rsp_* stable, both ready signals 0, busy=1; handshake on 4th clk -> IDLE and done_count increments once.
- req0 opcode 0x07 -> rsp_valid 1 clk after accept; err=1, result=0x00, flags=0; alu_opcode unchanged from the previous op.
- rst_n pulsed low during EXEC of XOR 0xAA^0x55 -> all outputs 0 immediately; no response; next request is served normally with req0 priority.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles every handshake and datapath signal of alu_arbiter so that the
// arbiter and its environment connect through a single port.
//
// Signal groups:
//   req0_* / req1_*  two requester channels (valid/ready + opcode, a, b)
//   alu_*            registered operation to the shared Alu and its result/flags
//   rsp_*            tagged response channel (valid/ready, id, result, flags, err)
//   busy, done_count status
//
// Modports:
//   slave   the arbiter itself
//   master  the surrounding control path / Alu / response consumer
// -----------------------------------------------------------------------------
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_opcode;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;

  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_opcode;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;

  logic [7:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic        alu_zero;
  logic        alu_carry;
  logic        alu_negative;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_result;
  logic [2:0]  rsp_flags;
  logic        rsp_err;

  logic        busy;
  logic [15:0] done_count;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    output req1_ready,
    output alu_opcode, alu_a, alu_b,
    input  alu_result, alu_zero, alu_carry, alu_negative,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    input  rsp_ready,
    output busy, done_count
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_opcode, req1_a, req1_b,
    input  req1_ready,
    input  alu_opcode, alu_a, alu_b,
    output alu_result, alu_zero, alu_carry, alu_negative,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    output rsp_ready,
    input  busy, done_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational Alu between two requesters. A granted operation is
// registered onto the Alu inputs, the Alu result and flags are captured one
// cycle later, and a tagged response is held until the consumer takes it.
// Opcodes above OPCODE_MAX skip the Alu and return an error response at once.
//
// Parameters:
//   OPCODE_MAX  highest legal opcode
//   FIXED_PRIO  0 = round-robin, 1 = req0 always wins a conflict
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_arbiter_if.slave (requesters, Alu, response, status)
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int OPCODE_MAX = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_last_grant;
  logic [7:0]  r_alu_opcode;
  logic [7:0]  r_alu_a;
  logic [7:0]  r_alu_b;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [7:0]  r_rsp_result;
  logic [2:0]  r_rsp_flags;
  logic        r_rsp_err;
  logic [15:0] r_done_count;

  logic        w_grant;
  logic        w_accept;
  logic        w_legal;
  logic [7:0]  w_sel_opcode;
  logic [7:0]  w_sel_a;
  logic [7:0]  w_sel_b;

  // Grant: a lone requester always wins; on a conflict either req0 wins
  // (fixed priority) or the requester that did not win last time.
  // NOTE: every signal assigned in a combinational block gets a default at
  // the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
    end else begin
      w_grant = bus.req1_valid;
    end
  end

  assign w_accept       = (r_state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = w_accept && !w_grant;
  assign bus.req1_ready = w_accept &&  w_grant;

  assign w_sel_opcode = w_grant ? bus.req1_opcode : bus.req0_opcode;
  assign w_sel_a      = w_grant ? bus.req1_a      : bus.req0_a;
  assign w_sel_b      = w_grant ? bus.req1_b      : bus.req0_b;
  assign w_legal      = (w_sel_opcode <= 8'(OPCODE_MAX));

  // Illegal opcodes bypass EXEC: the error response needs no Alu result.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_legal ? EXEC : RESP;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state and data registers use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;  // so req0 wins the first conflict
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
      r_done_count <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_grant;
            r_rsp_id     <= w_grant;
            if (w_legal) begin
              r_alu_opcode <= w_sel_opcode;
              r_alu_a      <= w_sel_a;
              r_alu_b      <= w_sel_b;
            end else begin
              // Alu registers keep the previous operation.
              r_rsp_valid  <= 1'b1;
              r_rsp_err    <= 1'b1;
              r_rsp_result <= '0;
              r_rsp_flags  <= '0;
            end
          end
        end
        EXEC: begin
          r_rsp_valid  <= 1'b1;
          r_rsp_err    <= 1'b0;
          r_rsp_result <= bus.alu_result;
          r_rsp_flags  <= {bus.alu_negative, bus.alu_carry, bus.alu_zero};
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_done_count <= r_done_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_opcode = r_alu_opcode;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_flags  = r_rsp_flags;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done_count = r_done_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Drives a round-robin and a fixed-priority alu_arbiter with the same request
// stimulus. Each instance has its own Alu model and a transaction-level
// reference model; a compare process checks both every cycle, and directed
// tests pin the model with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  localparam int OPMAX = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, v1, rr;
  logic [7:0] op0, a0, b0, op1, a1, b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter_if bus_rr ();
  alu_arbiter_if bus_fp ();

  assign bus_rr.req0_valid  = v0;
  assign bus_rr.req0_opcode = op0;
  assign bus_rr.req0_a      = a0;
  assign bus_rr.req0_b      = b0;
  assign bus_rr.req1_valid  = v1;
  assign bus_rr.req1_opcode = op1;
  assign bus_rr.req1_a      = a1;
  assign bus_rr.req1_b      = b1;
  assign bus_rr.rsp_ready   = rr;

  assign bus_fp.req0_valid  = v0;
  assign bus_fp.req0_opcode = op0;
  assign bus_fp.req0_a      = a0;
  assign bus_fp.req0_b      = b0;
  assign bus_fp.req1_valid  = v1;
  assign bus_fp.req1_opcode = op1;
  assign bus_fp.req1_a      = a1;
  assign bus_fp.req1_b      = b1;
  assign bus_fp.rsp_ready   = rr;

  // Alu: 0 AND, 1 OR, 2 ADD (carry out), 3 SUB, 4 XOR; flags {neg, carry, zero}.
  typedef struct packed {
    logic [7:0] res;
    logic [2:0] flags;
  } alu_out_t;

  function automatic alu_out_t alu_fn(logic [7:0] op, logic [7:0] a, logic [7:0] b);
    alu_out_t   o;
    logic [8:0] sum;
    logic       c;
    sum = {1'b0, a} + {1'b0, b};
    c   = 1'b0;
    case (op)
      8'd0:    o.res = a & b;
      8'd1:    o.res = a | b;
      8'd2:    begin o.res = sum[7:0]; c = sum[8]; end
      8'd3:    o.res = a - b;
      8'd4:    o.res = a ^ b;
      default: o.res = 8'h00;
    endcase
    o.flags = {o.res[7], c, (o.res == 8'h00)};
    return o;
  endfunction

  alu_out_t w_rr_alu, w_fp_alu;
  assign w_rr_alu            = alu_fn(bus_rr.alu_opcode, bus_rr.alu_a, bus_rr.alu_b);
  assign bus_rr.alu_result   = w_rr_alu.res;
  assign bus_rr.alu_negative = w_rr_alu.flags[2];
  assign bus_rr.alu_carry    = w_rr_alu.flags[1];
  assign bus_rr.alu_zero     = w_rr_alu.flags[0];
  assign w_fp_alu            = alu_fn(bus_fp.alu_opcode, bus_fp.alu_a, bus_fp.alu_b);
  assign bus_fp.alu_result   = w_fp_alu.res;
  assign bus_fp.alu_negative = w_fp_alu.flags[2];
  assign bus_fp.alu_carry    = w_fp_alu.flags[1];
  assign bus_fp.alu_zero     = w_fp_alu.flags[0];

  alu_arbiter #(.OPCODE_MAX(OPMAX), .FIXED_PRIO(0)) u_dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr)
  );

  alu_arbiter #(.OPCODE_MAX(OPMAX), .FIXED_PRIO(1)) u_dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fp)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one pending transaction at a time. `cnt` is the number of
  // edges still to pass before the response is visible.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          busy;
    int          cnt;
    bit          last;
    bit          id;
    logic [7:0]  res;
    logic [2:0]  flags;
    bit          err;
    logic [7:0]  aop, aa, ab;
    logic [15:0] done;
  } model_t;

  model_t m_rr, m_fp;

  function automatic model_t reset_model();
    model_t s;
    s.busy = 0; s.cnt = 0; s.last = 1; s.id = 0; s.res = '0; s.flags = '0;
    s.err = 0; s.aop = '0; s.aa = '0; s.ab = '0; s.done = '0;
    return s;
  endfunction

  function automatic int grant_of(model_t s, bit fp);
    if (v0 && v1) return fp ? 0 : (s.last ? 0 : 1);
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic model_t step(model_t s, bit fp);
    model_t     n;
    int         g;
    logic [7:0] op, a, b;
    alu_out_t   r;
    n = s;
    if (!s.busy) begin
      g = grant_of(s, fp);
      if (g >= 0) begin
        op = (g == 1) ? op1 : op0;
        a  = (g == 1) ? a1  : a0;
        b  = (g == 1) ? b1  : b0;
        n.busy = 1;
        n.last = (g == 1);
        n.id   = (g == 1);
        if (int'(op) <= OPMAX) begin
          r = alu_fn(op, a, b);
          n.aop = op; n.aa = a; n.ab = b;
          n.res = r.res; n.flags = r.flags; n.err = 0; n.cnt = 1;
        end else begin
          n.res = '0; n.flags = '0; n.err = 1; n.cnt = 0;
        end
      end
    end else if (s.cnt > 0) begin
      n.cnt = s.cnt - 1;
    end else if (rr) begin
      n.busy = 0;
      n.done = s.done + 16'd1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rr <= reset_model();
      m_fp <= reset_model();
    end else begin
      m_rr <= step(m_rr, 1'b0);
      m_fp <= step(m_fp, 1'b1);
    end
  end

  task automatic compare_dut(string tag, model_t m, bit fp,
                             logic r0, logic r1, logic [7:0] aop, logic [7:0] aa,
                             logic [7:0] ab, logic rv, logic id, logic [7:0] res,
                             logic [2:0] fl, logic err, logic bsy, logic [15:0] dc);
    bit exp_rv;
    exp_rv = m.busy && (m.cnt == 0);
    check({tag, "_req0_ready"}, 32'(r0), 32'(!m.busy && grant_of(m, fp) == 0));
    check({tag, "_req1_ready"}, 32'(r1), 32'(!m.busy && grant_of(m, fp) == 1));
    check({tag, "_alu_opcode"}, 32'(aop), 32'(m.aop));
    check({tag, "_alu_a"}, 32'(aa), 32'(m.aa));
    check({tag, "_alu_b"}, 32'(ab), 32'(m.ab));
    check({tag, "_rsp_valid"}, 32'(rv), 32'(exp_rv));
    check({tag, "_busy"}, 32'(bsy), 32'(m.busy));
    check({tag, "_done_count"}, 32'(dc), 32'(m.done));
    if (exp_rv) begin
      check({tag, "_rsp_id"}, 32'(id), 32'(m.id));
      check({tag, "_rsp_result"}, 32'(res), 32'(m.res));
      check({tag, "_rsp_flags"}, 32'(fl), 32'(m.flags));
      check({tag, "_rsp_err"}, 32'(err), 32'(m.err));
    end
  endtask

  always @(negedge clk) begin
    compare_dut("rr", m_rr, 1'b0, bus_rr.req0_ready, bus_rr.req1_ready,
                bus_rr.alu_opcode, bus_rr.alu_a, bus_rr.alu_b, bus_rr.rsp_valid,
                bus_rr.rsp_id, bus_rr.rsp_result, bus_rr.rsp_flags, bus_rr.rsp_err,
                bus_rr.busy, bus_rr.done_count);
    compare_dut("fp", m_fp, 1'b1, bus_fp.req0_ready, bus_fp.req1_ready,
                bus_fp.alu_opcode, bus_fp.alu_a, bus_fp.alu_b, bus_fp.rsp_valid,
                bus_fp.rsp_id, bus_fp.rsp_result, bus_fp.rsp_flags, bus_fp.rsp_err,
                bus_fp.busy, bus_fp.done_count);
  end

  // Presents one request, waits for its accept, then returns at the first
  // falling edge showing rsp_valid; lat counts clocks from the accept edge.
  task automatic send(input bit r, input logic [7:0] op, input logic [7:0] a,
                      input logic [7:0] b, output int lat);
    bit seen;
    @(posedge clk); #1;
    if (r) begin op1 = op; a1 = a; b1 = b; v1 = 1'b1; end
    else   begin op0 = op; a0 = a; b0 = b; v0 = 1'b1; end
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = r ? bus_rr.req1_ready : bus_rr.req0_ready;
    end
    if (!seen) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    lat  = 0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      lat++;
      seen = bus_rr.rsp_valid;
    end
    if (!seen) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int k = 0; k < 20 && !idle; k++) begin
      @(negedge clk);
      idle = !bus_rr.busy && !bus_fp.busy;
    end
    if (!idle) check("idle_timeout", 32'd0, 32'd1);
  endtask

  int          lat;
  int          log_rr[$];
  int          log_fp[$];
  logic [7:0]  snap_res;
  logic [2:0]  snap_fl;

  initial begin
    v0 = 0; v1 = 0; rr = 0;
    op0 = '0; a0 = '0; b0 = '0; op1 = '0; a1 = '0; b1 = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset_done_count", 32'(bus_rr.done_count), 32'd0);
    check("reset_rsp_valid", 32'(bus_rr.rsp_valid), 32'd0);
    check("reset_alu_opcode", 32'(bus_rr.alu_opcode), 32'd0);
    check("reset_busy", 32'(bus_rr.busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ADD 0xF0 + 0x20 from req0.
    rr = 1'b1;
    send(1'b0, 8'h02, 8'hF0, 8'h20, lat);
    check("add_latency", 32'(lat), 32'd2);
    check("add_id", 32'(bus_rr.rsp_id), 32'd0);
    check("add_result", 32'(bus_rr.rsp_result), 32'h10);
    check("add_flags", 32'(bus_rr.rsp_flags), 32'b010);
    check("add_err", 32'(bus_rr.rsp_err), 32'd0);
    @(posedge clk); @(negedge clk);
    check("add_done_count", 32'(bus_rr.done_count), 32'd1);

    // SUB from req1: zero result, then negative result.
    send(1'b1, 8'h03, 8'h05, 8'h05, lat);
    check("sub0_id", 32'(bus_rr.rsp_id), 32'd1);
    check("sub0_result", 32'(bus_rr.rsp_result), 32'h00);
    check("sub0_flags", 32'(bus_rr.rsp_flags), 32'b001);
    send(1'b1, 8'h03, 8'h01, 8'h02, lat);
    check("sub1_result", 32'(bus_rr.rsp_result), 32'hFF);
    check("sub1_flags", 32'(bus_rr.rsp_flags), 32'b100);
    wait_idle();
    check("sub_done_count", 32'(bus_rr.done_count), 32'd3);

    // Continuous conflict with AND ops.
    @(posedge clk); #1;
    op0 = 8'h00; a0 = 8'hF0; b0 = 8'h3C;
    op1 = 8'h00; a1 = 8'h0F; b1 = 8'h3C;
    v0 = 1'b1; v1 = 1'b1;
    for (int k = 0; k < 40 && log_rr.size() < 4; k++) begin
      @(negedge clk);
      if (bus_rr.req0_ready) log_rr.push_back(0);
      if (bus_rr.req1_ready) log_rr.push_back(1);
      if (bus_fp.req0_ready) log_fp.push_back(0);
      if (bus_fp.req1_ready) log_fp.push_back(1);
    end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    check("rr_accepts", 32'(log_rr.size()), 32'd4);
    check("fp_accepts", 32'(log_fp.size()), 32'd4);
    for (int k = 0; k < log_rr.size(); k++) check("rr_order", 32'(log_rr[k]), 32'(k % 2));
    for (int k = 0; k < log_fp.size(); k++) check("fp_order", 32'(log_fp[k]), 32'd0);
    wait_idle();
    check("conflict_done_count", 32'(bus_rr.done_count), 32'd7);

    // Back-pressure: hold rsp_ready low for 3 clocks in RESP.
    rr = 1'b0;
    send(1'b0, 8'h01, 8'h12, 8'h21, lat);
    check("or_result", 32'(bus_rr.rsp_result), 32'h33);
    snap_res = bus_rr.rsp_result;
    snap_fl  = bus_rr.rsp_flags;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus_rr.rsp_valid), 32'd1);
      check("hold_result", 32'(bus_rr.rsp_result), 32'(snap_res));
      check("hold_flags", 32'(bus_rr.rsp_flags), 32'(snap_fl));
      check("hold_ready", 32'({bus_rr.req0_ready, bus_rr.req1_ready}), 32'd0);
      check("hold_busy", 32'(bus_rr.busy), 32'd1);
    end
    @(posedge clk); #1 rr = 1'b1;
    @(posedge clk); @(negedge clk);
    check("hs_busy", 32'(bus_rr.busy), 32'd0);
    check("hs_done_count", 32'(bus_rr.done_count), 32'd8);
    @(negedge clk);
    check("hs_done_once", 32'(bus_rr.done_count), 32'd8);

    // Illegal opcode: one-clock error response, Alu registers untouched.
    send(1'b0, 8'h07, 8'h11, 8'h22, lat);
    check("ill_latency", 32'(lat), 32'd1);
    check("ill_err", 32'(bus_rr.rsp_err), 32'd1);
    check("ill_result", 32'(bus_rr.rsp_result), 32'h00);
    check("ill_flags", 32'(bus_rr.rsp_flags), 32'd0);
    check("ill_alu_opcode", 32'(bus_rr.alu_opcode), 32'h01);
    check("ill_alu_a", 32'(bus_rr.alu_a), 32'h12);
    @(posedge clk); @(negedge clk);
    check("ill_done_count", 32'(bus_rr.done_count), 32'd9);

    // Reset during EXEC of XOR.
    @(posedge clk); #1;
    op0 = 8'h04; a0 = 8'hAA; b0 = 8'h55; v0 = 1'b1;
    @(negedge clk);
    check("xor_ready", 32'(bus_rr.req0_ready), 32'd1);
    @(posedge clk); #1;
    v0 = 1'b0;
    check("xor_in_exec", 32'(bus_rr.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus_rr.busy), 32'd0);
    check("rst_alu_opcode", 32'(bus_rr.alu_opcode), 32'd0);
    check("rst_alu_a", 32'(bus_rr.alu_a), 32'd0);
    check("rst_rsp_valid", 32'(bus_rr.rsp_valid), 32'd0);
    check("rst_done_count", 32'(bus_rr.done_count), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_rsp", 32'(bus_rr.rsp_valid), 32'd0);

    // After reset req0 wins the first conflict.
    @(posedge clk); #1;
    op0 = 8'h04; a0 = 8'hAA; b0 = 8'h55;
    op1 = 8'h01; a1 = 8'h01; b1 = 8'h02;
    v0 = 1'b1; v1 = 1'b1;
    @(negedge clk);
    check("post_rst_grant0", 32'(bus_rr.req0_ready), 32'd1);
    check("post_rst_grant1", 32'(bus_rr.req1_ready), 32'd0);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk); @(negedge clk);
    check("xor_valid", 32'(bus_rr.rsp_valid), 32'd1);
    check("xor_id", 32'(bus_rr.rsp_id), 32'd0);
    check("xor_result", 32'(bus_rr.rsp_result), 32'hFF);
    check("xor_flags", 32'(bus_rr.rsp_flags), 32'b100);
    wait_idle();
    check("final_done_count", 32'(bus_rr.done_count), 32'd1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
